// File: rtl/dmx_pkg.sv
// Shared DMX512 definitions: timing derivations, receiver state encoding and
// the protocol slot limit. Used by both the DMX transmitter and dmx_rx.
package dmx_pkg;

    localparam int DMX_MAX_SLOTS = 512;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_BREAK = 3'd1,
        S_MAB   = 3'd2,
        S_START = 3'd3,
        S_DATA  = 3'd4,
        S_STOP  = 3'd5,
        S_WAIT  = 3'd6
    } dmx_rx_state_e;

    function automatic int dmx_bit_time(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    function automatic int dmx_clk_per_us(input int clk_freq);
        return clk_freq / 1000000;
    endfunction

    function automatic int dmx_break_min(input int clk_freq);
        return dmx_clk_per_us(clk_freq) * 88;
    endfunction

    function automatic int dmx_mab_min(input int clk_freq);
        return dmx_clk_per_us(clk_freq) * 8;
    endfunction

    function automatic int dmx_idle_max(input int clk_freq, input int idle_us);
        return dmx_clk_per_us(clk_freq) * idle_us;
    endfunction

endpackage

// File: rtl/dmx_rx_sync.sv
// DMX receive line conditioning: 2-FF synchronizer, falling-edge detect and a
// saturating low-time counter that flags a BREAK exactly once per low period.
module dmx_rx_sync
    import dmx_pkg::*;
#(
    parameter int BREAK_MIN = dmx_break_min(12090000)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    output logic rxs,
    output logic fall,
    output logic break_hit
);

    localparam int LOW_W = $clog2(BREAK_MIN + 2);

    logic             rx_meta_q;
    logic             rx_sync_q;
    logic             rx_prev_q;
    logic [LOW_W-1:0] low_cnt_q;
    logic [LOW_W-1:0] low_cnt_d;

    // Count consecutive low samples, saturating so a stuck-low line never wraps.
    always_comb begin
        low_cnt_d = low_cnt_q;
        if (rx_sync_q == 1'b1) begin
            low_cnt_d = '0;
        end else if (low_cnt_q != {LOW_W{1'b1}}) begin
            low_cnt_d = low_cnt_q + LOW_W'(1);
        end else begin
            low_cnt_d = low_cnt_q;
        end
    end

    // Synchronizer chain idles at mark (1) so reset never looks like a break.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            low_cnt_q <= '0;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            low_cnt_q <= low_cnt_d;
        end
    end

    assign rxs       = rx_sync_q;
    assign fall      = rx_prev_q & ~rx_sync_q;
    assign break_hit = (low_cnt_q == LOW_W'(BREAK_MIN));

endmodule

// File: rtl/dmx_rx.sv
// DMX512 receiver: BREAK/MAB detection, 8N2 slot decoding, EBR write port and
// packet status. Optional macro DMX_RX_STARTCODE_FILTER_EN: skip packets whose
// start code is not 0x00 (start_code still updates).
module dmx_rx
    import dmx_pkg::*;
#(
    parameter int CLK_FREQ  = 12090000,
    parameter int BAUD_RATE = 250000,
    parameter int MAX_SLOTS = DMX_MAX_SLOTS,
    parameter int IDLE_US   = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       enable,
    output logic       ebr_we,
    output logic [9:0] ebr_waddr,
    output logic [7:0] ebr_wdata,
    output logic [7:0] start_code,
    output logic [9:0] slot_count,
    output logic       frame_done,
    output logic       frame_err,
    output logic       busy
);

    localparam int BIT_TIME  = dmx_bit_time(CLK_FREQ, BAUD_RATE);
    localparam int HALF_BIT  = BIT_TIME / 2;
    localparam int BREAK_MIN = dmx_break_min(CLK_FREQ);
    localparam int MAB_MIN   = dmx_mab_min(CLK_FREQ);
    localparam int IDLE_MAX  = dmx_idle_max(CLK_FREQ, IDLE_US);
    localparam int CNT_W     = $clog2(IDLE_MAX + MAB_MIN + BIT_TIME + 1);

    logic rxs;
    logic fall;
    logic break_hit;

    dmx_rx_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [9:0]       slot_cnt_q, slot_cnt_d;
    logic             have_sc_q, have_sc_d;
    logic             brk_pend_q, brk_pend_d;
    logic             ebr_we_q, ebr_we_d;
    logic [9:0]       ebr_waddr_q, ebr_waddr_d;
    logic [7:0]       ebr_wdata_q, ebr_wdata_d;
    logic [7:0]       start_code_q, start_code_d;
    logic [9:0]       slot_count_q, slot_count_d;
    logic             frame_done_q, frame_done_d;
    logic             frame_err_q, frame_err_d;
    logic             busy_q, busy_d;

    dmx_rx_sync #(
        .BREAK_MIN (BREAK_MIN)
    ) u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .rxs       (rxs),
        .fall      (fall),
        .break_hit (break_hit)
    );

    // Next-state and registered-output logic; a break preempts every state.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        slot_cnt_d   = slot_cnt_q;
        have_sc_d    = have_sc_q;
        brk_pend_d   = brk_pend_q;
        ebr_we_d     = 1'b0;
        ebr_waddr_d  = ebr_waddr_q;
        ebr_wdata_d  = ebr_wdata_q;
        start_code_d = start_code_q;
        slot_count_d = slot_count_q;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
        busy_d       = busy_q;

        if (break_hit && ((state_q != S_IDLE) || enable)) begin
            // Close out the running packet before starting the new one.
            if (busy_q && (slot_cnt_q != 10'd0)) begin
                frame_done_d = 1'b1;
                slot_count_d = slot_cnt_q;
            end else begin
                frame_done_d = 1'b0;
            end
            state_d    = S_BREAK;
            busy_d     = 1'b1;
            slot_cnt_d = 10'd0;
            have_sc_d  = 1'b0;
            brk_pend_d = 1'b0;
            bit_idx_d  = 3'd0;
            cnt_d      = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    busy_d = 1'b0;
                end
                S_BREAK: begin
                    if (rxs) begin
                        state_d = S_MAB;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        state_d = S_BREAK;
                    end
                end
                S_MAB: begin
                    if (rxs) begin
                        if (cnt_q != {CNT_W{1'b1}}) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end else begin
                            cnt_d = cnt_q;
                        end
                    end else if (cnt_q < CNT_W'(MAB_MIN)) begin
                        frame_err_d = 1'b1;
                        busy_d      = 1'b0;
                        state_d     = S_IDLE;
                    end else begin
                        state_d = S_START;
                        cnt_d   = CNT_W'(1);
                    end
                end
                S_START: begin
                    if (cnt_q == CNT_W'(HALF_BIT)) begin
                        if (rxs) begin
                            frame_err_d = 1'b1;
                            busy_d      = 1'b0;
                            state_d     = S_IDLE;
                        end else begin
                            state_d   = S_DATA;
                            bit_idx_d = 3'd0;
                            cnt_d     = CNT_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (cnt_q == CNT_W'(BIT_TIME)) begin
                        shift_d = {rxs, shift_q[7:1]};
                        cnt_d   = CNT_W'(1);
                        if (bit_idx_q == 3'd7) begin
                            state_d = S_STOP;
                        end else begin
                            bit_idx_d = bit_idx_q + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (brk_pend_q) begin
                        // All-low byte with low stop bit: only a break excuses it.
                        if (rxs) begin
                            frame_err_d = 1'b1;
                            busy_d      = 1'b0;
                            brk_pend_d  = 1'b0;
                            state_d     = S_IDLE;
                        end else begin
                            state_d = S_STOP;
                        end
                    end else if (cnt_q != CNT_W'(BIT_TIME)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else if (!rxs) begin
                        if (shift_q == 8'h00) begin
                            brk_pend_d = 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                            busy_d      = 1'b0;
                            state_d     = S_IDLE;
                        end
                    end else if (!have_sc_q) begin
                        start_code_d = shift_q;
                        have_sc_d    = 1'b1;
                        cnt_d        = '0;
`ifdef DMX_RX_STARTCODE_FILTER_EN
                        if (shift_q != 8'h00) begin
                            busy_d  = 1'b0;
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_WAIT;
                        end
`else
                        state_d      = S_WAIT;
`endif
                    end else begin
                        ebr_we_d    = 1'b1;
                        ebr_waddr_d = slot_cnt_q;
                        ebr_wdata_d = shift_q;
                        slot_cnt_d  = slot_cnt_q + 10'd1;
                        cnt_d       = '0;
                        if (slot_cnt_q == 10'(MAX_SLOTS - 1)) begin
                            frame_done_d = 1'b1;
                            slot_count_d = 10'(MAX_SLOTS);
                            busy_d       = 1'b0;
                            state_d      = S_IDLE;
                        end else begin
                            state_d = S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (fall) begin
                        state_d = S_START;
                        cnt_d   = CNT_W'(1);
                    end else if (cnt_q == CNT_W'(IDLE_MAX - 1)) begin
                        if (slot_cnt_q != 10'd0) begin
                            frame_done_d = 1'b1;
                            slot_count_d = slot_cnt_q;
                        end else begin
                            frame_done_d = 1'b0;
                        end
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State, datapath and output registers; reset aborts any packet silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'h00;
            slot_cnt_q   <= 10'd0;
            have_sc_q    <= 1'b0;
            brk_pend_q   <= 1'b0;
            ebr_we_q     <= 1'b0;
            ebr_waddr_q  <= 10'd0;
            ebr_wdata_q  <= 8'h00;
            start_code_q <= 8'h00;
            slot_count_q <= 10'd0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            slot_cnt_q   <= slot_cnt_d;
            have_sc_q    <= have_sc_d;
            brk_pend_q   <= brk_pend_d;
            ebr_we_q     <= ebr_we_d;
            ebr_waddr_q  <= ebr_waddr_d;
            ebr_wdata_q  <= ebr_wdata_d;
            start_code_q <= start_code_d;
            slot_count_q <= slot_count_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
        end
    end

    assign ebr_we     = ebr_we_q;
    assign ebr_waddr  = ebr_waddr_q;
    assign ebr_wdata  = ebr_wdata_q;
    assign start_code = start_code_q;
    assign slot_count = slot_count_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_dmx_rx.sv
// Bench for dmx_rx: drives DMX packets on rx, scoreboards EBR writes and
// counts frame_done/frame_err pulses. Runs a faster bit rate to keep the
// 512-slot packet short; timing is expressed in clock cycles (12 per us).
`timescale 1ns/1ps
module tb_dmx_rx;

    localparam int CLK_FREQ  = 12000000;
    localparam int BAUD_RATE = 2000000;
    localparam int MAX_SLOTS = 512;
    localparam int IDLE_US   = 100;
    localparam int BT        = 6;      // clocks per bit
    localparam int BRK       = 1200;   // 100 us
    localparam int BRK_SHORT = 720;    // 60 us
    localparam int MAB       = 144;    // 12 us
    localparam int MAB_SHORT = 48;     // 4 us
    localparam int IDLE      = 1500;   // beyond the 1200-cycle idle limit

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic       enable;
    logic       ebr_we;
    logic [9:0] ebr_waddr;
    logic [7:0] ebr_wdata;
    logic [7:0] start_code;
    logic [9:0] slot_count;
    logic       frame_done;
    logic       frame_err;
    logic       busy;

    int          n_checks   = 0;
    int          n_errors   = 0;
    int          done_cnt   = 0;
    int          err_cnt    = 0;
    logic [9:0]  done_slots = 10'd0;
    logic        busy_seen  = 1'b0;
    int          pkt_addr   = 0;
    logic [17:0] sb_q[$];

    dmx_rx #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE),
        .MAX_SLOTS (MAX_SLOTS),
        .IDLE_US   (IDLE_US)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .enable     (enable),
        .ebr_we     (ebr_we),
        .ebr_waddr  (ebr_waddr),
        .ebr_wdata  (ebr_wdata),
        .start_code (start_code),
        .slot_count (slot_count),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on every write, tallies pulses.
    always @(negedge clk) begin
        if (ebr_we) begin
            if (sb_q.size() == 0) begin
                check("ebr_unexpected_we", {31'd0, ebr_we}, 32'd0);
            end else begin
                logic [17:0] exp_w;
                exp_w = sb_q.pop_front();
                check("ebr_write", {14'd0, ebr_waddr, ebr_wdata}, {14'd0, exp_w});
            end
        end
        if (frame_done) begin
            done_cnt++;
            done_slots = slot_count;
        end
        if (frame_err) err_cnt++;
        if (frame_done || frame_err)
            check("done_err_excl", {31'd0, frame_done & frame_err}, 32'd0);
        if (busy) busy_seen = 1'b1;
    end

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        hold(1'b0, BT);
        for (int i = 0; i < 8; i++) hold(b[i], BT);
        hold(stop_ok, BT);
        hold(1'b1, BT);
    endtask

    task automatic send_slot(input logic [7:0] b);
        sb_q.push_back({10'(pkt_addr), b});
        pkt_addr++;
        send_byte(b, 1'b1);
    endtask

    task automatic start_packet(input int brk, input int mab, input logic [7:0] sc);
        pkt_addr = 0;
        hold(1'b0, brk);
        hold(1'b1, mab);
        send_byte(sc, 1'b1);
    endtask

    initial begin
        int done0;
        int err0;
        rst_n  = 1'b0;
        rx     = 1'b1;
        enable = 1'b1;
        @(negedge clk);
        hold(1'b1, 4);
        check("reset_outputs", {ebr_we, ebr_waddr, ebr_wdata, start_code, slot_count,
                                frame_done, frame_err, busy}, 32'd0);
        rst_n = 1'b1;
        hold(1'b1, 20);

        // Basic 3-slot packet ended by idle.
        start_packet(BRK, MAB, 8'h00);
        send_slot(8'h11);
        send_slot(8'h22);
        send_slot(8'h33);
        hold(1'b1, IDLE);
        check("t1_done_cnt", done_cnt, 1);
        check("t1_slot_count", {22'd0, slot_count}, 32'd3);
        check("t1_start_code", {24'd0, start_code}, 32'h00);
        check("t1_busy", {31'd0, busy}, 32'd0);
        check("t1_sb_empty", sb_q.size(), 0);

        // Full 512-slot packet, extra bytes must be ignored.
        start_packet(BRK, MAB, 8'h00);
        for (int i = 0; i < 512; i++) send_slot(8'(i));
        check("t2_done_at_512", done_cnt, 2);
        check("t2_slot_count", {22'd0, done_slots}, 32'd512);
        check("t2_busy", {31'd0, busy}, 32'd0);
        send_byte(8'hAA, 1'b1);
        send_byte(8'h5A, 1'b1);
        send_byte(8'hA5, 1'b1);
        hold(1'b1, IDLE);
        check("t2_no_extra_done", done_cnt, 2);
        check("t2_sb_empty", sb_q.size(), 0);

        // Stop bit low on slot 5.
        done0 = done_cnt;
        err0  = err_cnt;
        start_packet(BRK, MAB, 8'h00);
        for (int i = 0; i < 4; i++) send_slot(8'h50 + 8'(i));
        send_byte(8'h55, 1'b0);
        hold(1'b1, IDLE);
        check("t3_err_cnt", err_cnt, err0 + 1);
        check("t3_no_done", done_cnt, done0);
        check("t3_busy", {31'd0, busy}, 32'd0);
        check("t3_sb_empty", sb_q.size(), 0);

        // New break after slot 10 closes the packet, next packet decodes.
        done0 = done_cnt;
        err0  = err_cnt;
        start_packet(BRK, MAB, 8'h00);
        for (int i = 0; i < 10; i++) send_slot(8'hA0 + 8'(i));
        start_packet(BRK, MAB, 8'h00);
        check("t4_done_on_break", done_cnt, done0 + 1);
        check("t4_slot_count", {22'd0, done_slots}, 32'd10);
        send_slot(8'h3C);
        send_slot(8'hC3);
        hold(1'b1, IDLE);
        check("t4_done_second", done_cnt, done0 + 2);
        check("t4_slot_count2", {22'd0, slot_count}, 32'd2);
        check("t4_no_err", err_cnt, err0);
        check("t4_sb_empty", sb_q.size(), 0);

        // Short break ignored, short MAB flagged.
        err0      = err_cnt;
        busy_seen = 1'b0;
        hold(1'b0, BRK_SHORT);
        hold(1'b1, 200);
        check("t5_short_break_busy", {31'd0, busy_seen}, 32'd0);
        check("t5_short_break_err", err_cnt, err0);
        hold(1'b0, BRK);
        hold(1'b1, MAB_SHORT);
        send_byte(8'h00, 1'b1);
        hold(1'b1, IDLE);
        check("t5_break_busy_seen", {31'd0, busy_seen}, 32'd1);
        check("t5_short_mab_err", err_cnt, err0 + 1);
        check("t5_busy", {31'd0, busy}, 32'd0);

        // Disabled receiver ignores breaks.
        enable    = 1'b0;
        busy_seen = 1'b0;
        start_packet(BRK, MAB, 8'h00);
        send_byte(8'h99, 1'b1);
        hold(1'b1, IDLE);
        check("t6_disabled_busy", {31'd0, busy_seen}, 32'd0);
        enable = 1'b1;

        // Non-zero start code.
        done0 = done_cnt;
        start_packet(BRK, MAB, 8'hCC);
        for (int i = 0; i < 5; i++) begin
`ifdef DMX_RX_STARTCODE_FILTER_EN
            send_byte(8'h70 + 8'(i), 1'b1);
`else
            send_slot(8'h70 + 8'(i));
`endif
        end
        hold(1'b1, IDLE);
        check("t7_start_code", {24'd0, start_code}, 32'hCC);
`ifdef DMX_RX_STARTCODE_FILTER_EN
        check("t7_done_cnt", done_cnt, done0);
`else
        check("t7_done_cnt", done_cnt, done0 + 1);
        check("t7_slot_count", {22'd0, slot_count}, 32'd5);
`endif
        check("t7_sb_empty", sb_q.size(), 0);

        // Reset in the middle of a slot aborts without a done pulse.
        done0 = done_cnt;
        start_packet(BRK, MAB, 8'h00);
        send_slot(8'h77);
        hold(1'b0, 20);
        rst_n = 1'b0;
        hold(1'b0, 2);
        check("t8_midreset_outputs", {ebr_we, ebr_waddr, ebr_wdata, start_code, slot_count,
                                      frame_done, frame_err, busy}, 32'd0);
        rst_n = 1'b1;
        hold(1'b1, IDLE);
        check("t8_no_done", done_cnt, done0);
        check("t8_sb_empty", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmx_rx.md
Name: dmx_rx

Overview:
- DMX512 receiver: the receive-side counterpart of the team's DMX transmitter.
- Decodes the RS-485 line: BREAK, MAB, start code, then up to 512 slots.
- Writes slot data into a DMX EBR write port for other logic to read.
- Reports start code, slot count, frame completion and framing errors.

Parameters:
- CLK_FREQ, 12090000, system clock frequency in Hz.
- BAUD_RATE, 250000, DMX bit rate in bit/s.
- MAX_SLOTS, 512, maximum data slots stored per packet (1..512).
- IDLE_US, 1000, mark-idle time in µs that ends a packet.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx  in  1  RS-485 receive line, asynchronous to clk
- enable  in  1  1 = accept new packets; sampled only in S_IDLE
- ebr_we  out  1  one-cycle write strobe to EBR
- ebr_waddr  out  10  EBR write address; slot n (n≥1) goes to address n-1
- ebr_wdata  out  8  slot data
- start_code  out  8  start code of the current/last packet
- slot_count  out  10  data slots stored in the last completed packet
- frame_done  out  1  one-cycle pulse at packet end
- frame_err  out  1  one-cycle pulse on bad stop bit or malformed start bit
- busy  out  1  high from break detect until packet end or abort

Behaviour:
- Reset is asynchronous, active-low (rst_n); clock is clk.
- Reset values: all outputs 0, state S_IDLE, synchronizer flops 1.
- Reset mid-packet: abort immediately; no write and no frame_done pulse.
- rx passes through a 2-FF synchronizer; all logic uses the synchronized value rxs.
- Timing constants:
  - BIT_TIME = CLK_FREQ/BAUD_RATE (48 at default).
  - HALF_BIT = BIT_TIME/2.
  - BREAK_MIN = (CLK_FREQ/1000000)*88.
  - MAB_MIN = (CLK_FREQ/1000000)*8.
  - IDLE_MAX = (CLK_FREQ/1000000)*IDLE_US.
- low_cnt is a free-running, saturating count of consecutive low rxs cycles; it clears when rxs goes high.
- low_cnt == BREAK_MIN asserts break from any state.
  - If the current packet holds ≥1 data slot, pulse frame_done and latch slot_count first.
  - Then go to S_BREAK with busy=1.
  - A byte in progress is discarded, with no frame_err.
- States:
  - S_IDLE: waits for a break. If enable=0, breaks are ignored and busy stays 0.
  - S_BREAK: waits for rxs high → S_MAB.
  - S_MAB: counts high cycles.
    - Low before MAB_MIN → frame_err pulse → S_IDLE.
    - Low at or after MAB_MIN → S_START.
  - S_START: waits HALF_BIT, then checks rxs.
    - rxs=1 → frame_err pulse → S_IDLE.
    - rxs=0 → S_DATA.
  - S_DATA: samples 8 bits at BIT_TIME intervals from the start-bit centre, LSB first, into a shift register.
  - S_STOP: samples rxs one BIT_TIME after the bit-7 sample.
    - rxs=0 and not a break → frame_err pulse → S_IDLE; slots already written remain.
    - rxs=1 → byte accepted → S_WAIT.
  - S_WAIT: mark between slots.
    - Falling edge of rxs → S_START.
    - High for IDLE_MAX cycles → frame_done → S_IDLE.
- Accepted bytes:
  - Slot 0 loads start_code; no EBR write.
  - Slots 1..MAX_SLOTS: ebr_we=1 for one cycle, the cycle after the stop-bit sample, with ebr_waddr/ebr_wdata valid in the same cycle.
  - Slot counter is 10 bits and increments after each write.
- Reaching MAX_SLOTS:
  - Pulse frame_done, slot_count=MAX_SLOTS, busy=0, → S_IDLE.
  - Further slots are ignored until the next break.
- frame_done:
  - slot_count is updated in the same cycle.
  - busy falls in the same cycle.
  - Never pulses for a packet with 0 data slots.
- frame_err and frame_done never pulse in the same cycle; a stop-bit error takes priority and suppresses frame_done.

Optional Feature:
- Macro: DMX_RX_STARTCODE_FILTER_EN.
- Defined:
  - A start code ≠ 0x00 still updates start_code.
  - All following slots of that packet are skipped: no writes, no frame_done.
  - The FSM waits in S_IDLE for the next break.
- Undefined: every start code is accepted and its slots are written.

Decomposition:
- Package dmx_pkg holds:
  - Timing localparam functions (BIT_TIME, BREAK_MIN, MAB_MIN, IDLE_MAX derivations).
  - State encodings.
  - DMX_MAX_SLOTS=512.
- Both DMX transmitter and dmx_rx use dmx_pkg.
- Sub-module dmx_rx_sync: 2-FF synchronizer plus saturating low-time counter. Outputs rxs, fall edge and break_hit.

Test Plan:
- Break 100 µs, MAB 12 µs, start code 0x00, 3 slots 0x11 0x22 0x33, then idle 1.2 ms → writes addr0=0x11, addr1=0x22, addr2=0x33; frame_done once; slot_count=3.
- 512-slot packet of incrementing data followed by extra bytes → 512 writes, addr 511=0xFF, frame_done at slot 512, extra bytes not written.
- Stop bit forced low on slot 5 → frame_err pulse, 4 writes kept, no frame_done, busy=0.
- New break arriving after slot 10 → frame_done with slot_count=10, then the new packet decodes normally.
- Break of only 60 µs → ignored (no busy); MAB of 4 µs → frame_err.
- Filter macro defined with start code 0xCC and 5 slots → start_code=0xCC, zero writes, no frame_done; same stimulus with the macro undefined → 5 writes.
